// File: rtl/prn_cdr_pkg.sv
// Shared types and helpers for the PRN CDR tapped delay line.
//   tap_w(depth) : width of a tap index for a line with `depth` taps
//   step_e       : decoded step request (none / down / up)
//   guard_st_e   : step guard FSM states (used when PRN_STEP_GUARD_EN is defined)
package prn_cdr_pkg;

  function automatic int tap_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_DEC  = 2'd1,
    STEP_INC  = 2'd2
  } step_e;

  typedef enum logic {
    READY = 1'b0,
    HOLD  = 1'b1
  } guard_st_e;

endpackage

// File: rtl/prn_dl_shift_chain.sv
// Enable-qualified register chain feeding the tap mux.
//   clk, rst   : clock, synchronous active-high reset (clears every stage)
//   en         : shift enable
//   din        : sample entering stage 0
//   line       : stage outputs, line[i] holds din delayed by i+1 enabled cycles
module prn_dl_shift_chain #(
  parameter int WIDTH = 1,
  parameter int NREGS = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic [WIDTH-1:0]             din,
  output logic [NREGS-1:0][WIDTH-1:0]  line
);

  always_ff @(posedge clk) begin
    if (rst) begin
      line <= '0;
    end else if (en) begin
      line[0] <= din;
      for (int i = 1; i < NREGS; i++) line[i] <= line[i-1];
    end
  end

endmodule

// File: rtl/prn_cdr_tap_delay_ctrl.sv
// Tapped delay line with steerable tap for the PRN CDR phase path.
// Step requests (sr: tap-1, sl: tap+1) from the loop filter move the tap that
// drives the retiming sampler; a direct load overrides any step.
// Optional feature macro: PRN_STEP_GUARD_EN adds a READY/HOLD guard that
// ignores steps for GUARD_CYCLES-1 cycles after each accepted step.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   en         : sample enable for the delay chain
//   sr, sl     : step down / step up requests
//   load       : load tap from load_tap (clamped to DEPTH-1)
//   din, dout  : sample in, registered sample from the selected tap
//   tap        : current tap index
//   at_min/max : tap at 0 / DEPTH-1
//   sat_err    : sticky, a step was blocked at a bound (WRAP=0)
//   busy       : step guard active (0 when the guard is not built)
module prn_cdr_tap_delay_ctrl
  import prn_cdr_pkg::*;
#(
  parameter int WIDTH        = 1,
  parameter int DEPTH        = 16,
  parameter int WRAP         = 1,
  parameter int INIT_TAP     = 0,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      sr,
  input  logic                      sl,
  input  logic                      load,
  input  logic [tap_w(DEPTH)-1:0]   load_tap,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          dout,
  output logic [tap_w(DEPTH)-1:0]   tap,
  output logic                      at_min,
  output logic                      at_max,
  output logic                      sat_err,
  output logic                      busy
);

  localparam int            TW      = tap_w(DEPTH);
  localparam logic [TW-1:0] MAX_TAP = TW'(DEPTH - 1);
  localparam logic [TW-1:0] INIT_T  = TW'(INIT_TAP);

  if (DEPTH < 2 || WIDTH < 1 || GUARD_CYCLES < 1 || INIT_TAP < 0 || INIT_TAP >= DEPTH) begin : g_param_chk
    $error("prn_cdr_tap_delay_ctrl: illegal parameter set");
  end

  // ---- delay chain and tap mux (index 0 is the undelayed input) ----
  logic [DEPTH-2:0][WIDTH-1:0] line;
  logic [DEPTH-1:0][WIDTH-1:0] mux_v;

  prn_dl_shift_chain #(.WIDTH(WIDTH), .NREGS(DEPTH-1)) u_chain (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .din  (din),
    .line (line)
  );

  assign mux_v = {line, din};

  // ---- step decode: opposing requests cancel ----
  step_e step;
  logic  step_ok;

  always_comb begin
    step = STEP_NONE;
    if (sr ^ sl) step = sr ? STEP_DEC : STEP_INC;
  end

`ifdef PRN_STEP_GUARD_EN
  localparam int GW = $clog2(GUARD_CYCLES + 1);

  guard_st_e      state, state_next;
  logic [GW-1:0]  gcnt, gcnt_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= READY;
      gcnt  <= '0;
    end else begin
      state <= state_next;
      gcnt  <= gcnt_next;
    end
  end

  // HOLD is left on the edge where the counter reaches zero, so the next
  // step lands exactly GUARD_CYCLES cycles after the previous one.
  always_comb begin
    state_next = state;
    gcnt_next  = gcnt;
    if (load) begin
      state_next = READY;
      gcnt_next  = '0;
    end else begin
      case (state)
        READY: if (step != STEP_NONE && GUARD_CYCLES > 1) begin
          state_next = HOLD;
          gcnt_next  = GW'(GUARD_CYCLES - 1);
        end
        HOLD: if (gcnt <= GW'(1)) begin
          state_next = READY;
          gcnt_next  = '0;
        end else begin
          gcnt_next  = gcnt - GW'(1);
        end
        default: begin
          state_next = READY;
          gcnt_next  = '0;
        end
      endcase
    end
  end

  always_comb begin
    busy    = (state == HOLD);
    step_ok = (state == READY) && (step != STEP_NONE);
  end
`else
  assign busy    = 1'b0;
  assign step_ok = (step != STEP_NONE);
`endif

  // ---- tap arithmetic ----
  logic [TW-1:0] tap_next;
  logic          sat_set;

  always_comb begin
    tap_next = tap;
    sat_set  = 1'b0;
    if (load) begin
      tap_next = (load_tap > MAX_TAP) ? MAX_TAP : load_tap;
    end else if (step_ok) begin
      if (step == STEP_DEC) begin
        if (tap == '0) begin
          if (WRAP != 0) tap_next = MAX_TAP;
          else           sat_set  = 1'b1;
        end else begin
          tap_next = tap - TW'(1);
        end
      end else begin
        if (tap == MAX_TAP) begin
          if (WRAP != 0) tap_next = '0;
          else           sat_set  = 1'b1;
        end else begin
          tap_next = tap + TW'(1);
        end
      end
    end
  end

  // dout follows tap_next so a tap change shows up on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      tap     <= INIT_T;
      dout    <= '0;
      sat_err <= 1'b0;
    end else begin
      tap  <= tap_next;
      dout <= mux_v[tap_next];
      if (load)         sat_err <= 1'b0;
      else if (sat_set) sat_err <= 1'b1;
    end
  end

  assign at_min = (tap == '0);
  assign at_max = (tap == MAX_TAP);

endmodule
